// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request bus between the MEM-stage controller (master) and a stalling
// memory (slave): one-cycle rd/wr strobes gated by busy, completion signalled by done.
interface mem_stage_ctrl_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_rd;
  logic          mem_wr;
  logic          mem_busy;
  logic          mem_done;
  logic [DW-1:0] mem_rdata;

  modport master (
    output mem_addr, mem_wdata, mem_rd, mem_wr,
    input  mem_busy, mem_done, mem_rdata
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_rd, mem_wr,
    output mem_busy, mem_done, mem_rdata
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: hits complete in the issue cycle, misses stall until done plus one
// RELEASE cycle; busy stalls without issuing. MEM_ALIGN_CHK_EN flags odd addresses instead.
module mem_stage_ctrl #(
  parameter int AW     = 16,
  parameter int DW     = 16,
  parameter int PERF_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     aluResult_XM,
  input  logic [DW-1:0]     readData2_XM,
  input  logic              memRead_XM,
  input  logic              memWrite_XM,
  input  logic              HALT_XM,
  mem_stage_ctrl_if.master  mem,
  output logic [DW-1:0]     readData_M,
  output logic              stall_M,
  output logic              err_M,
  output logic [PERF_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {IDLE, WAIT, RELEASE} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] rdata_q;
  logic          ld_q;
  logic          err_q;

  logic op, is_ld, conflict, misalign, go, issue;

  assign op       = (memRead_XM | memWrite_XM) & ~HALT_XM;
  assign is_ld    = memRead_XM & ~memWrite_XM;
  assign conflict = memRead_XM & memWrite_XM;
`ifdef MEM_ALIGN_CHK_EN
  assign misalign = aluResult_XM[0];
`else
  assign misalign = 1'b0;
`endif
  assign go    = op & ~misalign;
  assign issue = (state == IDLE) & go & ~mem.mem_busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (issue && !mem.mem_done) state_nxt = WAIT;
      WAIT:    if (mem.mem_done) state_nxt = RELEASE;
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Everything is forced low while reset is held, including the pass-through buses.
  always_comb begin
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    mem.mem_rd    = 1'b0;
    mem.mem_wr    = 1'b0;
    readData_M    = '0;
    stall_M       = 1'b0;
    err_M         = 1'b0;
    if (rst) begin
      mem.mem_addr  = aluResult_XM;
      mem.mem_wdata = readData2_XM;
      case (state)
        IDLE: begin
          if (op && misalign) begin
            err_M = 1'b1;
          end else if (go) begin
            if (mem.mem_busy) begin
              stall_M = 1'b1;
            end else begin
              mem.mem_wr = memWrite_XM;
              mem.mem_rd = ~memWrite_XM;
              if (mem.mem_done) begin
                readData_M = is_ld ? mem.mem_rdata : '0;
                err_M      = conflict;
              end else begin
                stall_M = 1'b1;
              end
            end
          end
        end
        WAIT:    stall_M = 1'b1;
        RELEASE: begin
          readData_M = ld_q ? rdata_q : '0;
          err_M      = err_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
      ld_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (issue) begin
        ld_q  <= is_ld;
        err_q <= conflict;
      end
      if (state == WAIT && mem.mem_done && ld_q) rdata_q <= mem.mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                stall_cycles <= '0;
    else if (stall_M && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed-vector bench: each cycle's expected response is queued by the stimulus and
// checked by an independent monitor on the falling edge.
module tb_mem_stage_ctrl;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int PW = 4;
  localparam int PMAX = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] alu;
  logic [DW-1:0] rd2;
  logic          mrd, mwr, halt;
  logic [DW-1:0] rdata_m;
  logic          stall, err;
  logic [PW-1:0] perf;

  mem_stage_ctrl_if #(.AW(AW), .DW(DW)) bus ();

  mem_stage_ctrl #(.AW(AW), .DW(DW), .PERF_W(PW)) dut (
    .clk          (clk),
    .rst          (rst),
    .aluResult_XM (alu),
    .readData2_XM (rd2),
    .memRead_XM   (mrd),
    .memWrite_XM  (mwr),
    .HALT_XM      (halt),
    .mem          (bus.master),
    .readData_M   (rdata_m),
    .stall_M      (stall),
    .err_M        (err),
    .stall_cycles (perf)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic          rd, wr, st, er;
    logic [DW-1:0] rdata;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [PW-1:0] perf;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++;
      if ({bus.mem_rd, bus.mem_wr, stall, err, rdata_m, bus.mem_addr, bus.mem_wdata, perf} !==
          {e.rd, e.wr, e.st, e.er, e.rdata, e.addr, e.wdata, e.perf}) begin
        n_bad++;
        $display("FAIL %s: got rd=%b wr=%b stall=%b err=%b rdata=%h addr=%h wdata=%h perf=%0d ; want rd=%b wr=%b stall=%b err=%b rdata=%h addr=%h wdata=%h perf=%0d",
                 e.name, bus.mem_rd, bus.mem_wr, stall, err, rdata_m, bus.mem_addr, bus.mem_wdata, perf,
                 e.rd, e.wr, e.st, e.er, e.rdata, e.addr, e.wdata, e.perf);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of stimulus, queue its expected response, advance one clock.
  task automatic cyc(input string nm, input logic r, input logic mr, input logic mw, input logic h,
                     input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic b, input logic d,
                     input logic [DW-1:0] md, input logic e_rd, input logic e_wr, input logic e_st,
                     input logic e_er, input logic [DW-1:0] e_rdata, input int e_perf);
    exp_t e;
    rst = r; mrd = mr; mwr = mw; halt = h; alu = a; rd2 = wd;
    bus.mem_busy = b; bus.mem_done = d; bus.mem_rdata = md;
    e.name = nm; e.rd = e_rd; e.wr = e_wr; e.st = e_st; e.er = e_er; e.rdata = e_rdata;
    e.addr  = r ? a : '0;
    e.wdata = r ? wd : '0;
    e.perf  = PW'((e_perf > PMAX) ? PMAX : e_perf);
    q.push_back(e);
    tick();
  endtask

  initial begin
    rst = 1'b0; mrd = 1'b0; mwr = 1'b0; halt = 1'b0; alu = '0; rd2 = '0;
    bus.mem_busy = 1'b0; bus.mem_done = 1'b0; bus.mem_rdata = '0;
    tick();
    //   name           rst rd wr h  addr     wdata    bsy dn rdata     | rd wr st er rdata   perf
    cyc("reset0",       0,  1, 0, 0, 16'h0010, 16'h7777, 0, 1, 16'hBEEF,  0, 0, 0, 0, 16'h0000, 0);
    cyc("reset1",       0,  1, 0, 0, 16'h0010, 16'h7777, 0, 1, 16'hBEEF,  0, 0, 0, 0, 16'h0000, 0);
    cyc("load_hit",     1,  1, 0, 0, 16'h0010, 16'h7777, 0, 1, 16'hBEEF,  1, 0, 0, 0, 16'hBEEF, 0);
    cyc("idle_a",       1,  0, 0, 0, 16'h0010, 16'h7777, 0, 0, 16'hBEEF,  0, 0, 0, 0, 16'h0000, 0);
    cyc("miss_issue",   1,  1, 0, 0, 16'h0020, 16'h0000, 0, 0, 16'h0000,  1, 0, 1, 0, 16'h0000, 0);
    cyc("miss_w1",      1,  1, 0, 0, 16'h0020, 16'h0000, 0, 0, 16'h0000,  0, 0, 1, 0, 16'h0000, 1);
    cyc("miss_w2",      1,  1, 0, 0, 16'h0020, 16'h0000, 0, 0, 16'h0000,  0, 0, 1, 0, 16'h0000, 2);
    cyc("miss_done",    1,  1, 0, 0, 16'h0020, 16'h0000, 0, 1, 16'h1234,  0, 0, 1, 0, 16'h0000, 3);
    cyc("miss_release", 1,  1, 0, 0, 16'h0020, 16'h0000, 0, 0, 16'hDEAD,  0, 0, 0, 0, 16'h1234, 4);
    cyc("idle_b",       1,  0, 0, 0, 16'h0020, 16'h0000, 0, 0, 16'hDEAD,  0, 0, 0, 0, 16'h0000, 4);
    cyc("st_busy1",     1,  0, 1, 0, 16'h0030, 16'hA5A5, 1, 0, 16'h0000,  0, 0, 1, 0, 16'h0000, 4);
    cyc("st_busy2",     1,  0, 1, 0, 16'h0030, 16'hA5A5, 1, 0, 16'h0000,  0, 0, 1, 0, 16'h0000, 5);
    cyc("st_issue",     1,  0, 1, 0, 16'h0030, 16'hA5A5, 0, 0, 16'h0000,  0, 1, 1, 0, 16'h0000, 6);
    cyc("st_done",      1,  0, 1, 0, 16'h0030, 16'hA5A5, 0, 1, 16'h5555,  0, 0, 1, 0, 16'h0000, 7);
    cyc("st_release",   1,  0, 1, 0, 16'h0030, 16'hA5A5, 0, 0, 16'h5555,  0, 0, 0, 0, 16'h0000, 8);
    cyc("idle_c",       1,  0, 0, 0, 16'h0030, 16'hA5A5, 0, 0, 16'h0000,  0, 0, 0, 0, 16'h0000, 8);
    cyc("rw_issue",     1,  1, 0, 0, 16'h0040, 16'h0000, 0, 0, 16'h0000,  1, 0, 1, 0, 16'h0000, 8);
    cyc("rw_wait",      1,  1, 0, 0, 16'h0040, 16'h0000, 0, 0, 16'h0000,  0, 0, 1, 0, 16'h0000, 9);
    cyc("rst_midwait",  0,  1, 0, 0, 16'h0040, 16'h0000, 0, 0, 16'h0000,  0, 0, 0, 0, 16'h0000, 0);
    cyc("late_done",    1,  0, 0, 0, 16'h0040, 16'h0000, 0, 1, 16'h6666,  0, 0, 0, 0, 16'h0000, 0);
    cyc("post_rst",     1,  0, 0, 0, 16'h0040, 16'h0000, 0, 0, 16'h0000,  0, 0, 0, 0, 16'h0000, 0);
    cyc("conf_hit",     1,  1, 1, 0, 16'h0050, 16'h0F0F, 0, 1, 16'h9999,  0, 1, 0, 1, 16'h0000, 0);
    cyc("conf_issue",   1,  1, 1, 0, 16'h0052, 16'h0F0F, 0, 0, 16'h0000,  0, 1, 1, 0, 16'h0000, 0);
    cyc("conf_done",    1,  1, 1, 0, 16'h0052, 16'h0F0F, 0, 1, 16'h9999,  0, 0, 1, 0, 16'h0000, 1);
    cyc("conf_release", 1,  1, 1, 0, 16'h0052, 16'h0F0F, 0, 0, 16'h9999,  0, 0, 0, 1, 16'h0000, 2);
    cyc("halt",         1,  1, 0, 1, 16'h0060, 16'h0000, 1, 0, 16'h0000,  0, 0, 0, 0, 16'h0000, 2);
`ifdef MEM_ALIGN_CHK_EN
    cyc("unaligned",    1,  1, 0, 0, 16'h0011, 16'h0000, 0, 1, 16'h4321,  0, 0, 0, 1, 16'h0000, 2);
`else
    cyc("unaligned",    1,  1, 0, 0, 16'h0011, 16'h0000, 0, 1, 16'h4321,  1, 0, 0, 0, 16'h4321, 2);
`endif
    cyc("idle_d",       1,  0, 0, 0, 16'h0011, 16'h0000, 0, 0, 16'h0000,  0, 0, 0, 0, 16'h0000, 2);
    // Long busy stretch drives the narrow counter into saturation.
    for (int i = 0; i < 18; i++)
      cyc("sat_busy",   1,  1, 0, 0, 16'h0070, 16'h0000, 1, 0, 16'h0000,  0, 0, 1, 0, 16'h0000, 2 + i);
    cyc("sat_hit",      1,  1, 0, 0, 16'h0070, 16'h0000, 0, 1, 16'h2468,  1, 0, 0, 0, 16'h2468, 20);
    cyc("sat_hold",     1,  0, 0, 0, 16'h0070, 16'h0000, 0, 0, 16'h0000,  0, 0, 0, 0, 16'h0000, 20);
    tick();
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d vectors left unchecked, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Memory-stage controller directly downstream of the EX/MEM pipeline register.
- Consumes the latched address, store data and memory-control bits. Drives a multi-cycle stalling data-memory interface (cache or banked memory with busy/done handshake).
- Produces load data for the MEM/WB register.
- Raises stall_M, which the pipeline uses to deassert the enable of EX/MEM and all upstream registers and to insert a bubble into MEM/WB.

Parameters:
- AW, 16, address width
- DW, 16, data width
- PERF_W, 16, width of the saturating stall-cycle counter

Ports:
- clk  in  1  clock, rising-edge
- rst  in  1  asynchronous, active-low reset
- aluResult_XM  in  AW  memory address from EX/MEM
- readData2_XM  in  DW  store data from EX/MEM
- memRead_XM  in  1  load request
- memWrite_XM  in  1  store request
- HALT_XM  in  1  halt in MEM; suppresses new accesses
- mem_busy  in  1  memory cannot accept a request this cycle
- mem_done  in  1  access completes this cycle; mem_rdata valid for loads
- mem_rdata  in  DW  memory read data
- mem_addr  out  AW  address to memory
- mem_wdata  out  DW  write data to memory
- mem_rd  out  1  one-cycle read request strobe
- mem_wr  out  1  one-cycle write request strobe
- readData_M  out  DW  load result to MEM/WB
- stall_M  out  1  freeze upstream; bubble MEM/WB
- err_M  out  1  illegal access flag to MEM/WB
- stall_cycles  out  PERF_W  saturating count of cycles with stall_M=1

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, rdata_q=0, stall_cycles=0.
  - All outputs are 0. mem_addr and mem_wdata are 0 while in reset.
  - Reset mid-access abandons the access. No strobe is re-issued after reset.
- Combinational paths:
  - mem_addr = aluResult_XM.
  - mem_wdata = readData2_XM.
  - These hold stable while stall_M=1, because EX/MEM is frozen.
- op = (memRead_XM | memWrite_XM) & ~HALT_XM.
- IDLE state:
  - op=0: no strobe, stall_M=0, readData_M=0.
  - op=1, mem_busy=1: no strobe, stall_M=1, stay in IDLE.
  - op=1, mem_busy=0: assert mem_wr if memWrite_XM, otherwise mem_rd, for exactly this cycle.
    - mem_done=1 in the same cycle (hit): stall_M=0, readData_M=mem_rdata (0 for stores), stay in IDLE. Zero-stall completion.
    - mem_done=0: stall_M=1, next state=WAIT.
- WAIT state:
  - Strobes are 0 and stall_M=1.
  - On mem_done: capture rdata_q=mem_rdata (loads only) and go to RELEASE. stall_M is still 1 in this cycle.
  - mem_done with no outstanding access is ignored in IDLE and RELEASE.
- RELEASE state:
  - stall_M=0, readData_M=rdata_q, no strobe. MEM/WB and EX/MEM advance at the end of this cycle.
  - Go to IDLE unconditionally. No re-issue for the instruction still visible on the EX/MEM outputs.
- One access at a time: at most one strobe per instruction.
- memRead_XM and memWrite_XM both 1 is illegal:
  - The access is treated as a store only.
  - err_M=1 during the cycle in which stall_M=0 for that instruction.
- HALT_XM=1: no strobe, stall_M=0. A halt never waits on memory.
- stall_cycles:
  - Increments on every cycle with stall_M=1.
  - Saturates at 2^PERF_W-1 and never wraps.
- readData_M is 0 whenever no load is completing in the current cycle.

Optional Feature:
- Macro: MEM_ALIGN_CHK_EN.
- Defined:
  - op with aluResult_XM[0]=1 (unaligned word) issues no strobe and does not stall.
  - err_M=1 for that cycle and readData_M=0.
- Undefined:
  - The address is passed unmodified and memory handles it.
  - err_M is driven only by the read+write conflict.

Test Plan:
1. Reset then load hit:
   - Stimulus: rst low 2 cycles, then rise; memRead_XM=1, aluResult_XM=0x0010, mem_busy=0, mem_done=1, mem_rdata=0xBEEF in the same cycle.
   - Response: mem_rd pulses 1 cycle, readData_M=0xBEEF, stall_M never 1, stall_cycles=0.
2. Load miss of 3 cycles:
   - Stimulus: mem_done arrives 3 cycles after the strobe, mem_rdata=0x1234.
   - Response: stall_M=1 for 4 cycles, then RELEASE with readData_M=0x1234 and stall_M=0. Single mem_rd pulse. stall_cycles=4.
3. Store blocked by busy:
   - Stimulus: memWrite_XM=1, readData2_XM=0xA5A5, mem_busy=1 for 2 cycles, then done after 1 cycle.
   - Response: mem_wr pulses once, in the first cycle with mem_busy=0. mem_wdata=0xA5A5 throughout. stall_M covers every blocked and waiting cycle.
4. Reset mid-WAIT:
   - Stimulus: assert rst during WAIT.
   - Response: outputs go to 0 immediately, without waiting for a clock edge. After release, no strobe occurs until a new op is present. A late mem_done has no effect.
5. Conflict and halt:
   - Stimulus: memRead_XM=memWrite_XM=1 as a hit.
   - Response: mem_wr only, err_M=1.
   - Stimulus: HALT_XM=1 with memRead_XM=1.
   - Response: no strobe, stall_M=0.
6. With MEM_ALIGN_CHK_EN:
   - Stimulus: aluResult_XM=0x0011 load.
   - Response: no strobe, err_M=1 for 1 cycle, readData_M=0.
   - Without the macro, the same stimulus issues mem_rd.
